// File: rtl/neighbor_info_bank_arbiter_pkg.sv
// rtl/neighbor_info_bank_arbiter_pkg.sv - Neighbor-Info SRAM widths and bank arbiter types
package neighbor_info_bank_arbiter_pkg;

  localparam int NEIGHBOR_NUM_BANK = 4;
  localparam int NEIGHBOR_ROW_W    = 8;
  localparam int NEIGHBOR_DATA_W   = 17;
  localparam int BANK_W            = $clog2(NEIGHBOR_NUM_BANK);

  typedef logic [NEIGHBOR_DATA_W-1:0] neighbor_info_t;

  typedef struct packed {
    logic                      valid;
    logic [BANK_W-1:0]         bank;
    logic [NEIGHBOR_ROW_W-1:0] row;
  } neighbor_arb_req_t;

  typedef struct packed {
    logic           valid;
    neighbor_info_t data;
  } neighbor_arb_resp_t;

  typedef struct packed {
    logic                      cen;
    logic                      wen;
    logic [NEIGHBOR_ROW_W-1:0] a;
  } neighbor_sram_if_t;

endpackage

// File: rtl/neighbor_rr_arbiter.sv
// rtl/neighbor_rr_arbiter.sv - N-way round-robin grant; pointer moves past the winner on a grant
module neighbor_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;

  // N is a power of two, so the IW-bit sum wraps modulo N for free
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + IW'(k);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
    gnt = gnt_valid ? (N'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_valid) begin
      ptr <= gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/neighbor_info_bank_arbiter.sv
// rtl/neighbor_info_bank_arbiter.sv - shares banked Neighbor-Info SRAM among read requesters
// Optional conflict counters: define NEIGHBOR_ARB_PERF_EN.
module neighbor_info_bank_arbiter
  import neighbor_info_bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BANK = NEIGHBOR_NUM_BANK,
  parameter int ROW_W    = NEIGHBOR_ROW_W,
  parameter int DATA_W   = NEIGHBOR_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*(BANK_W+ROW_W)-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [NUM_REQ*DATA_W-1:0]     resp_data,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [NUM_BANK-1:0]           sram_cen,
  output logic [NUM_BANK-1:0]           sram_wen,
  output logic [NUM_BANK*ROW_W-1:0]     sram_a,
  input  logic [NUM_BANK*DATA_W-1:0]    sram_q
`ifdef NEIGHBOR_ARB_PERF_EN
  ,
  output logic [NUM_BANK*16-1:0]        perf_conflict_cnt
`endif
);

  localparam int ADDR_W = BANK_W + ROW_W;
  localparam int IDX_W  = $clog2(NUM_REQ);

  neighbor_arb_req_t  req      [NUM_REQ];
  neighbor_arb_resp_t resp_q   [NUM_REQ];
  neighbor_sram_if_t  sram_if  [NUM_BANK];
  logic [NUM_REQ-1:0] inflight;
  logic [BANK_W-1:0]  src_bank [NUM_REQ];
  logic [ROW_W-1:0]   a_hold   [NUM_BANK];
  logic [NUM_REQ-1:0] bank_req [NUM_BANK];
  logic [NUM_REQ-1:0] bank_gnt [NUM_BANK];
  logic [IDX_W-1:0]   bank_idx [NUM_BANK];
  logic [NUM_BANK-1:0] bank_hit;

  // req.valid carries eligibility, not just the raw request
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      req[r].valid = !reset && req_valid[r] && !inflight[r] &&
                     (!resp_q[r].valid || resp_ready[r]);
      req[r].bank  = req_addr[r*ADDR_W+ROW_W +: BANK_W];
      req[r].row   = req_addr[r*ADDR_W +: ROW_W];
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        bank_req[b][r] = req[r].valid && (req[r].bank == BANK_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    neighbor_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (bank_req[b]),
      .gnt       (bank_gnt[b]),
      .gnt_idx   (bank_idx[b]),
      .gnt_valid (bank_hit[b])
    );
  end

  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      req_ready = req_ready | bank_gnt[b];
    end
  end

  // Idle banks keep their last row on A to avoid needless toggling
  always_comb begin
    sram_cen = '1;
    sram_wen = '1;
    sram_a   = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      sram_if[b].cen = !bank_hit[b];
      sram_if[b].wen = 1'b1;
      sram_if[b].a   = reset ? '0 : (bank_hit[b] ? req[bank_idx[b]].row : a_hold[b]);
      sram_cen[b]    = sram_if[b].cen;
      sram_wen[b]    = sram_if[b].wen;
      sram_a[b*ROW_W +: ROW_W] = sram_if[b].a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        resp_q[r]   <= '0;
        src_bank[r] <= '0;
      end
      for (int b = 0; b < NUM_BANK; b++) begin
        a_hold[b] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (inflight[r]) begin
          resp_q[r].valid <= 1'b1;
          resp_q[r].data  <= sram_q[int'(src_bank[r])*DATA_W +: DATA_W];
        end else if (resp_q[r].valid && resp_ready[r]) begin
          resp_q[r].valid <= 1'b0;
        end
        inflight[r] <= req_ready[r];
        if (req_ready[r]) begin
          src_bank[r] <= req[r].bank;
        end
      end
      for (int b = 0; b < NUM_BANK; b++) begin
        if (bank_hit[b]) begin
          a_hold[b] <= sram_if[b].a;
        end
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      resp_valid[r] = resp_q[r].valid;
      resp_data[r*DATA_W +: DATA_W] = resp_q[r].data;
    end
  end

`ifdef NEIGHBOR_ARB_PERF_EN
  logic [15:0] conflict_cnt [NUM_BANK];

  // More than one bit set means at least two eligible requesters collide on the bank
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        conflict_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (((bank_req[b] & (bank_req[b] - NUM_REQ'(1))) != '0) &&
            (conflict_cnt[b] != 16'hFFFF)) begin
          conflict_cnt[b] <= conflict_cnt[b] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    perf_conflict_cnt = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      perf_conflict_cnt[b*16 +: 16] = conflict_cnt[b];
    end
  end
`endif

endmodule

// File: tb/tb_neighbor_info_bank_arbiter.sv
// tb/tb_neighbor_info_bank_arbiter.sv - directed self-checking bench for neighbor_info_bank_arbiter
module tb_neighbor_info_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [39:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [67:0] resp_data;
  logic [3:0]  resp_ready;
  logic [3:0]  sram_cen;
  logic [3:0]  sram_wen;
  logic [31:0] sram_a;
  logic [67:0] sram_q = '0;
`ifdef NEIGHBOR_ARB_PERF_EN
  logic [63:0] perf_conflict_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int accepts;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  neighbor_info_bank_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_a     (sram_a),
    .sram_q     (sram_q)
`ifdef NEIGHBOR_ARB_PERF_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] mem_word(input int b, input logic [7:0] row);
    if (b == 1 && row == 8'h2A) return 17'h1ABCD;
    return {2'(b), row, row[6:0] ^ 7'h35};
  endfunction

  // Behavioural SRAM: q updates the cycle after CEN low, holds otherwise
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!sram_cen[b]) sram_q[b*17 +: 17] <= mem_word(b, sram_a[b*8 +: 8]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input int b, input int row);
    req_valid[r] = v;
    req_addr[r*10 +: 10] = {2'(b), 8'(row)};
  endtask

  function automatic logic [16:0] rdata(input int r);
    return resp_data[r*17 +: 17];
  endfunction

  function automatic logic [7:0] addr_of(input int b);
    return sram_a[b*8 +: 8];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_addr = '0;
    resp_ready = '0;
    set_req(0, 1'b1, 1, 8'h2A);
    step();
    step();
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_cen", 32'(sram_cen), 32'hF);
    check("rst_a", sram_a, 32'h0);
    check("wen_const", 32'(sram_wen), 32'hF);
    reset = 1'b0;
    req_valid = '0;
    step();

    // single read
    set_req(0, 1'b1, 1, 8'h2A);
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    check("single_cen", 32'(sram_cen), 32'hD);
    check("single_a", 32'(addr_of(1)), 32'h2A);
    step();
    req_valid = '0;
    #1;
    check("single_t1_valid", 32'(resp_valid), 32'h0);
    check("single_t1_cen", 32'(sram_cen), 32'hF);
    check("single_a_hold", 32'(addr_of(1)), 32'h2A);
    step();
    check("single_t2_valid", 32'(resp_valid), 32'h1);
    check("single_t2_data", 32'(rdata(0)), 32'h1ABCD);
    resp_ready = 4'hF;
    step();
    check("single_t3_valid", 32'(resp_valid), 32'h0);

    // parallel, one requester per bank
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, r, 8'h10 + r);
    #1;
    check("par_ready", 32'(req_ready), 32'hF);
    check("par_cen", 32'(sram_cen), 32'h0);
    for (int b = 0; b < 4; b++) check("par_a", 32'(addr_of(b)), 32'h10 + b);
    step();
    req_valid = '0;
    step();
    check("par_valid", 32'(resp_valid), 32'hF);
    for (int r = 0; r < 4; r++) check("par_data", 32'(rdata(r)), 32'(mem_word(r, 8'(8'h10 + r))));
    step();
    check("par_drain", 32'(resp_valid), 32'h0);

    // reset the cycle after a grant
    set_req(0, 1'b1, 2, 8'h05);
    #1;
    check("rmf_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    reset = 1'b1;
    #1;
    check("rmf_ready_in_rst", 32'(req_ready), 32'h0);
    check("rmf_cen_in_rst", 32'(sram_cen), 32'hF);
    step();
    check("rmf_no_resp0", 32'(resp_valid), 32'h0);
    reset = 1'b0;
    step();
    check("rmf_no_resp1", 32'(resp_valid), 32'h0);
    set_req(1, 1'b1, 0, 8'h07);
    #1;
    check("rmf_next_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    check("rmf_next_valid", 32'(resp_valid), 32'h2);
    check("rmf_next_data", 32'(rdata(1)), 32'(mem_word(0, 8'h07)));
    step();
    check("rmf_next_drain", 32'(resp_valid), 32'h0);

    // all requesters hold bank 2: round-robin starts from reset pointer 0
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 2, 8'h20 + r);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_grant", 32'(req_ready), 32'(4'b0001 << exp_order[i]));
      if (i == 2) begin
        check("rr_r0_valid", 32'(resp_valid[0]), 32'h1);
        check("rr_r0_data", 32'(rdata(0)), 32'(mem_word(2, 8'h20)));
      end
      step();
    end
`ifdef NEIGHBOR_ARB_PERF_EN
    check("perf_bank2", 32'(perf_conflict_cnt[2*16 +: 16]), 32'd5);
    check("perf_bank0", 32'(perf_conflict_cnt[0 +: 16]), 32'd0);
`endif
    req_valid = '0;
    step();
    step();
    step();
    check("rr_drain", 32'(resp_valid), 32'h0);

    // backpressure on requester 1
    resp_ready = 4'b1101;
    set_req(1, 1'b1, 3, 8'h33);
    #1;
    check("bp_ready0", 32'(req_ready), 32'h2);
    step();
    set_req(1, 1'b1, 3, 8'h44);
    #1;
    check("bp_inflight_block", 32'(req_ready), 32'h0);
    step();
    check("bp_held_valid", 32'(resp_valid[1]), 32'h1);
    check("bp_held_block", 32'(req_ready), 32'h0);
    check("bp_held_data", 32'(rdata(1)), 32'(mem_word(3, 8'h33)));
    step();
    check("bp_held_valid2", 32'(resp_valid[1]), 32'h1);
    check("bp_held_data2", 32'(rdata(1)), 32'(mem_word(3, 8'h33)));
    check("bp_held_block2", 32'(req_ready), 32'h0);
    resp_ready = 4'hF;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'h2);
    check("bp_release_a", 32'(addr_of(3)), 32'h44);
    step();
    req_valid = '0;
    #1;
    check("bp_consumed", 32'(resp_valid[1]), 32'h0);
    step();
    check("bp_new_valid", 32'(resp_valid), 32'h2);
    check("bp_new_data", 32'(rdata(1)), 32'(mem_word(3, 8'h44)));
    step();

    // back-to-back on requester 0
    accepts = 0;
    set_req(0, 1'b1, 0, 8'h01);
    for (int i = 0; i < 10; i++) begin
      #1;
      accepts += int'(req_ready[0]);
      step();
    end
    check("b2b_accepts", 32'(accepts), 32'd5);
    req_valid = '0;
    #1;
    check("b2b_idle_cen", 32'(sram_cen[0]), 32'h1);
    check("b2b_idle_a_hold", 32'(addr_of(0)), 32'h01);
    check("b2b_last_valid", 32'(resp_valid[0]), 32'h1);
    check("b2b_last_data", 32'(rdata(0)), 32'(mem_word(0, 8'h01)));
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
